// File: rtl/regwrite_pkg.sv
// regwrite_pkg: shared widths and queue entry type
// for the register file write-back queue.
package regwrite_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } entry_t;

endpackage

// File: rtl/regwrite_fifo.sv
// regwrite_fifo: circular in-order store of pending
// register writes with per-slot valid bits and flush.
module regwrite_fifo
    import regwrite_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  entry_t                     push_entry,
    input  logic                       pop,
    input  logic                       flush,
    output entry_t [DEPTH-1:0]         entries,
    output logic   [DEPTH-1:0]         valid,
    output logic   [$clog2(DEPTH)-1:0] head,
    output logic   [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] tail;

    // Pointer, occupancy and storage update; flush keeps stale data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            valid   <= '0;
            entries <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
        end else begin
            if (push) begin
                entries[tail] <= push_entry;
                valid[tail]   <= 1'b1;
                tail          <= tail + 1'b1;
            end
            if (pop) begin
                valid[head] <= 1'b0;
                head        <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/regwrite_queue.sv
// regwrite_queue: buffered write-back sequencer with
// pending scoreboard and forwarding (REGWRITE_DROP_ZERO_EN).
module regwrite_queue
    import regwrite_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_ADDR_W-1:0] in_addr,
    input  logic [REG_DATA_W-1:0] in_data,
    input  logic                  drain_en,
    input  logic                  flush,
    output logic [REG_ADDR_W-1:0] Aw,
    output logic [REG_DATA_W-1:0] Dw,
    output logic                  WrEn,
    output logic [$clog2(DEPTH):0] count,
    output logic [NUM_REGS-1:0]   pending,
    input  logic [REG_ADDR_W-1:0] fwd_addr_a,
    input  logic [REG_ADDR_W-1:0] fwd_addr_b,
    output logic                  fwd_hit_a,
    output logic                  fwd_hit_b,
    output logic [REG_DATA_W-1:0] fwd_data_a,
    output logic [REG_DATA_W-1:0] fwd_data_b
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    entry_t [DEPTH-1:0] entries;
    logic   [DEPTH-1:0] valid;
    logic   [PW-1:0]    head;
    logic   [PW-1:0]    idx;
    entry_t             head_entry;
    entry_t             push_entry;
    logic               keep;
    logic               push;
    logic [REG_ADDR_W-1:0] last_addr;
    logic [REG_DATA_W-1:0] last_data;

`ifdef REGWRITE_DROP_ZERO_EN
    assign keep = (in_addr != '0);
`else
    assign keep = 1'b1;
`endif

    assign in_ready   = (count < CW'(DEPTH));
    assign push       = in_valid && in_ready && !flush && keep;
    assign push_entry = '{addr: in_addr, data: in_data};
    assign head_entry = entries[head];
    assign WrEn       = (count != '0) && drain_en && !flush;
    assign Aw         = (count != '0) ? head_entry.addr : last_addr;
    assign Dw         = (count != '0) ? head_entry.data : last_data;

    regwrite_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (WrEn),
        .flush      (flush),
        .entries    (entries),
        .valid      (valid),
        .head       (head),
        .count      (count)
    );

    // Hold the last issued write so Aw/Dw stay stable when empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_addr <= '0;
            last_data <= '0;
        end else if (WrEn) begin
            last_addr <= head_entry.addr;
            last_data <= head_entry.data;
        end
    end

    // Scoreboard: one-hot OR of queued destinations, r0 excluded.
    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && entries[i].addr != '0)
                pending[entries[i].addr] = 1'b1;
        end
    end

    // Forwarding search from head to tail; later (newer) match wins.
    always_comb begin
        fwd_hit_a  = 1'b0;
        fwd_hit_b  = 1'b0;
        fwd_data_a = '0;
        fwd_data_b = '0;
        idx        = head;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if (valid[idx] && fwd_addr_a != '0 &&
                entries[idx].addr == fwd_addr_a) begin
                fwd_hit_a  = 1'b1;
                fwd_data_a = entries[idx].data;
            end
            if (valid[idx] && fwd_addr_b != '0 &&
                entries[idx].addr == fwd_addr_b) begin
                fwd_hit_b  = 1'b1;
                fwd_data_b = entries[idx].data;
            end
        end
    end

endmodule
